// File: rtl/mem_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl_if
// Description : Bundle of the request/grant signals between the pipeline
//               stages and the memory-port controller, plus the strobes and
//               data of the single 256-byte memory port.
//               master : the controller (initiator of the memory port)
//               slave  : the environment (pipeline stages + memory)
// Ports       : none (signal bundle only)
//               Fetch  : if_req, if_addr -> if_gnt, if_data
//               Data   : dm_req, dm_we, dm_addr, dm_wdata -> dm_gnt, dm_rdata
//               Irq/PC : irq -> irq_ack, pc_load, pc_value
//               Status : stall_cnt
//               Memory : mem_read, mem_write, mem_addr, mem_wdata <- mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_ctrl_if;
    // Fetch stage
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt;
    logic [7:0] if_data;
    // Memory (data) stage
    logic       dm_req;
    logic       dm_we;
    logic [7:0] dm_addr;
    logic [7:0] dm_wdata;
    logic       dm_gnt;
    logic [7:0] dm_rdata;
    // Interrupt / PC redirect
    logic       irq;
    logic       irq_ack;
    logic       pc_load;
    logic [7:0] pc_value;
    // Status
    logic [7:0] stall_cnt;
    // Memory port
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, irq, mem_rdata,
        output if_gnt, if_data, dm_gnt, dm_rdata, irq_ack, pc_load, pc_value,
               stall_cnt, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, irq, mem_rdata,
        input  if_gnt, if_data, dm_gnt, dm_rdata, irq_ack, pc_load, pc_value,
               stall_cnt, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_ctrl
// Description : Memory-port initiator for the 8-bit pipelined processor.
//               Owns the single port of the 256-byte Von Neumann memory,
//               arbitrates data load/store > interrupt vector > fetch,
//               sequences the reset-vector and interrupt-vector fetches and
//               returns zero-latency grants/read data to the stages.
// Ports       : clk   - clock
//               reset - synchronous, active-high reset
//               bus   - mem_port_ctrl_if.master (request/grant + memory port)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_ctrl #(
    parameter logic [7:0] RESET_VEC = 8'h00,
    parameter logic [7:0] INT_VEC   = 8'h01
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_port_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_IVEC = 2'd2
    } state_t;

    localparam logic [7:0] c_STALL_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t     r_state;
    logic       r_irq_q;
    logic       r_irq_pend;
    logic [7:0] r_stall_cnt;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    state_t     w_next;
    logic       w_if_gnt;
    logic [7:0] w_if_data;
    logic       w_dm_gnt;
    logic [7:0] w_dm_rdata;
    logic       w_irq_ack;
    logic       w_pc_load;
    logic [7:0] w_pc_value;
    logic       w_mem_read;
    logic       w_mem_write;
    logic [7:0] w_mem_addr;
    logic [7:0] w_mem_wdata;
    logic       w_irq_rise;
    logic       w_stall_inc;

    always_comb begin
        w_next      = r_state;
        w_if_gnt    = 1'b0;
        w_if_data   = 8'h00;
        w_dm_gnt    = 1'b0;
        w_dm_rdata  = 8'h00;
        w_irq_ack   = 1'b0;
        w_pc_load   = 1'b0;
        w_pc_value  = 8'h00;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem_addr  = 8'h00;
        w_mem_wdata = 8'h00;

        case (r_state)
            ST_BOOT: begin
                w_mem_read = 1'b1;
                w_mem_addr = RESET_VEC;
                w_pc_load  = 1'b1;
                w_pc_value = bus.mem_rdata;
                w_next     = ST_RUN;
            end

            ST_RUN: begin
                if (bus.dm_req) begin
                    w_dm_gnt   = 1'b1;
                    w_mem_addr = bus.dm_addr;
                    if (bus.dm_we) begin
                        w_mem_write = 1'b1;
                        w_mem_wdata = bus.dm_wdata;
                    end else begin
                        w_mem_read = 1'b1;
                        w_dm_rdata = bus.mem_rdata;
                    end
                end else if (r_irq_pend) begin
                    // Port is left idle for one cycle so the vector fetch
                    // starts from a clean RUN->IVEC transition.
                    w_next = ST_IVEC;
                end else if (bus.if_req) begin
                    w_if_gnt   = 1'b1;
                    w_mem_read = 1'b1;
                    w_mem_addr = bus.if_addr;
                    w_if_data  = bus.mem_rdata;
                end
            end

            ST_IVEC: begin
                w_mem_read = 1'b1;
                w_mem_addr = INT_VEC;
                w_pc_load  = 1'b1;
                w_pc_value = bus.mem_rdata;
                w_irq_ack  = 1'b1;
                w_next     = ST_RUN;
            end

            default: begin
                w_next = ST_BOOT;
            end
        endcase

        // Every output is forced quiet while reset is held.
        if (reset) begin
            w_if_gnt    = 1'b0;
            w_if_data   = 8'h00;
            w_dm_gnt    = 1'b0;
            w_dm_rdata  = 8'h00;
            w_irq_ack   = 1'b0;
            w_pc_load   = 1'b0;
            w_pc_value  = 8'h00;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_mem_addr  = 8'h00;
            w_mem_wdata = 8'h00;
        end
    end

    assign w_irq_rise  = bus.irq & ~r_irq_q;
    assign w_stall_inc = bus.if_req & ~w_if_gnt;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_BOOT;
            r_irq_q     <= 1'b0;
            r_irq_pend  <= 1'b0;
            r_stall_cnt <= 8'h00;
        end else begin
            r_state <= w_next;
            r_irq_q <= bus.irq;
            // A new edge in the same cycle as the IVEC clear survives.
            r_irq_pend <= w_irq_rise | (r_irq_pend & (r_state != ST_IVEC));
            if (w_stall_inc && (r_stall_cnt != c_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.if_gnt    = w_if_gnt;
    assign bus.if_data   = w_if_data;
    assign bus.dm_gnt    = w_dm_gnt;
    assign bus.dm_rdata  = w_dm_rdata;
    assign bus.irq_ack   = w_irq_ack;
    assign bus.pc_load   = w_pc_load;
    assign bus.pc_value  = w_pc_value;
    assign bus.stall_cnt = reset ? 8'h00 : r_stall_cnt;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_ctrl
// Description : Self-checking bench for mem_port_ctrl. A behavioural 256-byte
//               memory (async read, sync write) sits on the memory port.
//               Vector records carry inputs and expected outputs; expected
//               outputs go into a scoreboard queue when inputs are driven and
//               are popped and compared mid-cycle.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_ctrl;

    logic clk;
    logic reset;
    logic mem_init;

    mem_port_ctrl_if bus ();

    mem_port_ctrl #(
        .RESET_VEC (8'h00),
        .INT_VEC   (8'h01)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory
    logic [7:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem[8'h00] <= 8'h10;
            mem[8'h01] <= 8'h80;
            mem[8'h10] <= 8'hC0;
            mem[8'h11] <= 8'hA1;
            mem[8'h12] <= 8'h3C;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [7:0]  if_addr;
        logic        dm_req;
        logic        dm_we;
        logic [7:0]  dm_addr;
        logic [7:0]  dm_wdata;
        logic        irq;
        logic [53:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [53:0] sb_q[$];
    int          total;
    int          bad;
    int          vec_no;

    function automatic vec_t mk(
        input logic rst, input logic ifr, input logic [7:0] ifa,
        input logic dmr, input logic dmw, input logic [7:0] dma,
        input logic [7:0] dmd, input logic irq,
        input logic ifg, input logic [7:0] ifd, input logic dmg,
        input logic [7:0] dmrd, input logic ack, input logic pcl,
        input logic [7:0] pcv, input logic [7:0] stl, input logic mrd,
        input logic mwr, input logic [7:0] ma, input logic [7:0] mwd);
        vec_t v;
        v.rst = rst; v.if_req = ifr; v.if_addr = ifa;
        v.dm_req = dmr; v.dm_we = dmw; v.dm_addr = dma; v.dm_wdata = dmd;
        v.irq = irq;
        v.exp = {ifg, ifd, dmg, dmrd, ack, pcl, pcv, stl, mrd, mwr, ma, mwd};
        return v;
    endfunction

    function automatic logic [53:0] actual();
        return {bus.if_gnt, bus.if_data, bus.dm_gnt, bus.dm_rdata, bus.irq_ack,
                bus.pc_load, bus.pc_value, bus.stall_cnt, bus.mem_read,
                bus.mem_write, bus.mem_addr, bus.mem_wdata};
    endfunction

    task automatic step(input vec_t v);
        logic [53:0] e;
        logic [53:0] a;
        reset        = v.rst;
        bus.if_req   = v.if_req;
        bus.if_addr  = v.if_addr;
        bus.dm_req   = v.dm_req;
        bus.dm_we    = v.dm_we;
        bus.dm_addr  = v.dm_addr;
        bus.dm_wdata = v.dm_wdata;
        bus.irq      = v.irq;
        sb_q.push_back(v.exp);
        @(negedge clk);
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard vec%0d: got empty queue, want an entry", vec_no);
        end else begin
            e = sb_q.pop_front();
            a = actual();
            if (a !== e) begin
                bad++;
                $display("FAIL vec%0d outputs: got=%h want=%h (ifg,ifd,dmg,dmrd,ack,pcl,pcv,stall,rd,wr,addr,wdata)",
                         vec_no, a, e);
            end
        end
        total++;
        if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) begin
            bad++;
            $display("FAIL vec%0d strobes: got rd=1 wr=1, want not both", vec_no);
        end
        vec_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; vec_no = 0;
        reset = 1'b1; mem_init = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 8'h00;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 8'h00; bus.dm_wdata = 8'h00;
        bus.irq = 1'b0;
        @(posedge clk); #1;
        mem_init = 1'b0;

        //             rst ifr ifa    dmr dmw dma    dmd    irq | ifg ifd    dmg dmrd   ack pcl pcv    stall  rd wr addr   wdata
        tbl.push_back(mk(1, 1, 8'h10, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00)); // in reset
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 1, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00)); // BOOT
        tbl.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 0,  1, 8'hC0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00)); // fetch
        tbl.push_back(mk(0, 1, 8'h12, 1, 1, 8'h40, 8'h55, 0,  0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h40, 8'h55)); // store wins
        tbl.push_back(mk(0, 1, 8'h12, 0, 0, 8'h00, 8'h00, 0,  1, 8'h3C, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 8'h12, 8'h00)); // fetch after
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h40, 8'h00, 0,  0, 8'h00, 1, 8'h55, 0, 0, 8'h00, 8'h01, 1, 0, 8'h40, 8'h00)); // load back
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00)); // idle
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00)); // irq edge
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00)); // idle RUN
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 1, 1, 8'h80, 8'h01, 1, 0, 8'h01, 8'h00)); // IVEC
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1,  1, 8'hA1, 0, 8'h00, 0, 0, 8'h00, 8'h01, 1, 0, 8'h11, 8'h00)); // no retrigger
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00)); // irq edge
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h40, 8'h00, 1,  0, 8'h00, 1, 8'h55, 0, 0, 8'h00, 8'h01, 1, 0, 8'h40, 8'h00)); // data 1
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 8'h41, 8'h77, 1,  0, 8'h00, 1, 8'h00, 0, 0, 8'h00, 8'h01, 0, 1, 8'h41, 8'h77)); // data 2
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 8'h41, 8'h00, 1,  0, 8'h00, 1, 8'h77, 0, 0, 8'h00, 8'h01, 1, 0, 8'h41, 8'h00)); // data 3
        tbl.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h01, 0, 0, 8'h00, 8'h00)); // idle RUN
        tbl.push_back(mk(0, 1, 8'h10, 1, 0, 8'h40, 8'h00, 1,  0, 8'h00, 0, 8'h00, 1, 1, 8'h80, 8'h02, 1, 0, 8'h01, 8'h00)); // IVEC, dm waits
        tbl.push_back(mk(0, 1, 8'h10, 1, 0, 8'h40, 8'h00, 1,  0, 8'h00, 1, 8'h55, 0, 0, 8'h00, 8'h03, 1, 0, 8'h40, 8'h00));
        tbl.push_back(mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 1,  1, 8'hC0, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 0, 8'h10, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h04, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h04, 0, 0, 8'h00, 8'h00)); // pend set
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00)); // reset drops it
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 1, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00)); // BOOT
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00)); // RUN, no ack
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00)); // irq edge
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00)); // idle RUN
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 1, 1, 8'h80, 8'h01, 1, 0, 8'h01, 8'h00)); // IVEC + edge
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h02, 0, 0, 8'h00, 8'h00)); // set won
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1,  0, 8'h00, 0, 8'h00, 1, 1, 8'h80, 8'h03, 1, 0, 8'h01, 8'h00)); // 2nd IVEC
        tbl.push_back(mk(0, 1, 8'h11, 0, 0, 8'h00, 8'h00, 1,  1, 8'hA1, 0, 8'h00, 0, 0, 8'h00, 8'h04, 1, 0, 8'h11, 8'h00));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h04, 0, 0, 8'h00, 8'h00));

        foreach (tbl[i]) step(tbl[i]);

        // Fetch starved by back-to-back loads: counter climbs from 4 and
        // must stop at 255.
        for (int i = 0; i < 300; i++) begin
            int s;
            s = (4 + i > 255) ? 255 : 4 + i;
            step(mk(0, 1, 8'h10, 1, 0, 8'h40, 8'h00, 0,
                    0, 8'h00, 1, 8'h55, 0, 0, 8'h00, 8'(s), 1, 0, 8'h40, 8'h00));
        end

        // Counter holds at saturation once the fetch is finally served.
        step(mk(0, 1, 8'h10, 0, 0, 8'h00, 8'h00, 0,
                1, 8'hC0, 0, 8'h00, 0, 0, 8'h00, 8'hFF, 1, 0, 8'h10, 8'h00));

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard drain: got %0d leftover, want 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish before limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
